// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes {bout, diff} = a - b - bin one bit per clock, LSB first.
// Optional feature: define SERSUB_OVF_EN to add the ovf port (two's-complement overflow flag).
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERSUB_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               bit_a;
    logic               bit_b;
    logic               d_bit;
    logic               br_nxt;
    logic               last_bit;

    // Full-subtractor cell for the bit currently selected by the counter
    always_comb begin
        bit_a    = a_q[cnt_q];
        bit_b    = b_q[cnt_q];
        d_bit    = bit_a ^ bit_b ^ br_q;
        br_nxt   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERSUB_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE falls back to IDLE unless a new op is accepted back-to-back
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                br_d         = br_nxt;
                res_d[cnt_q] = d_bit;
                cnt_d        = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d  = res_d;
                    bout_d  = br_nxt;
`ifdef SERSUB_OVF_EN
                    ovf_d   = br_q ^ br_nxt;
`endif
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_BUSY);
        done_d = (state_d == S_DONE);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERSUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERSUB_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] prev_diff = 8'h00;
    logic       prev_bout = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bin   = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: busy=%b done=%b, expected busy=0 done=0", busy, done);
        end
        checks++;
        if (diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: diff=%h bout=%b, expected diff=00 bout=0", diff, bout);
        end
`ifdef SERSUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: ovf=%b, expected 0", ovf);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One operation: checks busy/hold every cycle, done exactly 8 edges after acceptance.
    // glitch_k > 0 pulses start with other operands after BUSY edge glitch_k (must be ignored).
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          input logic [7:0] ed, input logic eb, input logic eovf,
                          input int glitch_k, input string nm);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ia; b = ~ib; bin = ~ibin;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: busy=%b done=%b, expected busy=1 done=0", nm, busy, done);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k < 8) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || diff !== prev_diff || bout !== prev_bout) begin
                    errors++;
                    $display("FAIL %s_busy%0d: busy=%b done=%b diff=%h bout=%b, expected busy=1 done=0 diff=%h bout=%b",
                             nm, k, busy, done, diff, bout, prev_diff, prev_bout);
                end
                if (k == glitch_k) begin
                    start = 1'b1; a = 8'hAA; b = 8'h01; bin = 1'b1;
                end
            end else begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_done: busy=%b done=%b, expected busy=0 done=1", nm, busy, done);
                end
                checks++;
                if (diff !== ed || bout !== eb) begin
                    errors++;
                    $display("FAIL %s_result: diff=%h bout=%b, expected diff=%h bout=%b", nm, diff, bout, ed, eb);
                end
`ifdef SERSUB_OVF_EN
                checks++;
                if (ovf !== eovf) begin
                    errors++;
                    $display("FAIL %s_ovf: ovf=%b, expected %b", nm, ovf, eovf);
                end
`endif
            end
        end
        prev_diff = ed;
        prev_bout = eb;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== ed || bout !== eb) begin
            errors++;
            $display("FAIL %s_after: busy=%b done=%b diff=%h bout=%b, expected busy=0 done=0 diff=%h bout=%b",
                     nm, busy, done, diff, bout, ed, eb);
        end
    endtask

    task automatic test_basic();
        run_op(8'h3C, 8'h15, 1'b0, 8'h27, 1'b0, 1'b0, 0, "basic");
    endtask

    task automatic test_borrow();
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0, "zero_minus_one");
        run_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, 0, "borrow_in");
    endtask

    task automatic test_overflow();
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, "ovf_set");
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, "ovf_clear");
    endtask

    task automatic test_ignored_start();
        run_op(8'h3C, 8'h15, 1'b0, 8'h27, 1'b0, 1'b0, 3, "ignore_start");
    endtask

    task automatic test_reset_mid_busy();
        @(negedge clk);
        a = 8'h3C; b = 8'h15; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: busy=%b done=%b diff=%h bout=%b, expected all 0", busy, done, diff, bout);
        end
`ifdef SERSUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ovf: ovf=%b, expected 0", ovf);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet%0d: busy=%b done=%b, expected busy=0 done=0", k, busy, done);
            end
        end
        prev_diff = 8'h00;
        prev_bout = 1'b0;
        run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, "post_reset");
    endtask

    // Start held high through DONE: the edge closing DONE accepts, done returns 8 edges later.
    task automatic test_back_to_back();
        @(negedge clk);
        a = 8'h3C; b = 8'h15; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 7) begin
                start = 1'b1; a = 8'hFF; b = 8'h0F; bin = 1'b0;
            end
        end
        checks++;
        if (done !== 1'b1 || diff !== 8'h27 || bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: done=%b diff=%h bout=%b, expected done=1 diff=27 bout=0", done, diff, bout);
        end
        @(posedge clk); #1;
        start = 1'b0; a = 8'h00; b = 8'h00;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_idle: busy=%b done=%b, expected busy=1 done=0", busy, done);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k < 8) begin
                if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h27) begin
                    errors++;
                    $display("FAIL b2b_busy%0d: busy=%b done=%b diff=%h, expected busy=1 done=0 diff=27", k, busy, done, diff);
                end
            end else begin
                if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'hF0 || bout !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second: busy=%b done=%b diff=%h bout=%b, expected busy=0 done=1 diff=F0 bout=0",
                             busy, done, diff, bout);
                end
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: busy=%b done=%b, expected busy=0 done=0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_ignored_start();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
